clk_period_meter: RTL and testbench
===================================

Name: clk_period_meter

Overview:
- Receiving end of the divided-clock path. Takes a slow square wave, such as a divided clock from a divider or an external test pin, and synchronises it into the system clock domain.
- Detects its rising edges and measures the period in system-clock cycles.
- Publishes each completed measurement with a one-cycle valid strobe. Flags a timeout when edges stop arriving.
- Used to self-check divider settings on the board and to drive 7-segment frequency readouts.

Parameters:
- CNT_WIDTH, 16, width of the period counter and the period output. Saturation value is 2^CNT_WIDTH-1.
- SYNC_STAGES, 2, number of flip-flops in the input synchroniser. Must be at least 2.

Ports:
- clk_in, input, 1, system clock. All logic is on its rising edge.
- reset, input, 1, synchronous, active-high reset.
- sig_in, input, 1, asynchronous square wave to be measured.
- period, output, CNT_WIDTH, last completed period in clk_in cycles. Holds its value between updates.
- period_valid, output, 1, one-cycle pulse when period is updated.
- timeout, output, 1, level. High while no rising edge has arrived for 2^CNT_WIDTH-1 cycles.
- locked, output, 1, level. High once at least one valid period has been published since reset or timeout.

Behaviour:
- Clocking and reset: one clock, clk_in. reset is synchronous and active-high, sampled on the clk_in rising edge.
- Reset values:
  - period = 0, period_valid = 0, timeout = 0, locked = 0.
  - Internal counter cnt = 0. Synchroniser flops = 0. Edge-history flop = 0. FSM = IDLE.
- Synchroniser: sig_in passes through SYNC_STAGES flops to give s_sync. s_prev is s_sync delayed by one cycle.
- Edge detect: rise = s_sync & ~s_prev. Only rising edges are measured. Latency from a sig_in transition to rise is SYNC_STAGES+1 cycles.
- FSM states: IDLE, MEASURE, TIMEOUT.
- IDLE:
  - Waiting for the first edge. cnt is held at 0.
  - On rise: cnt <= 1, go to MEASURE. No period_valid, because a partial period is never reported.
- MEASURE:
  - On a cycle without rise: cnt <= cnt+1.
  - On rise: period <= cnt, period_valid <= 1 for one cycle, locked <= 1, cnt <= 1.
  - Two rises N cycles apart produce period = N. period_valid is high on the cycle after the second rise.
  - If cnt == 2^CNT_WIDTH-1 and there is no rise: go to TIMEOUT, timeout <= 1, locked <= 0. period keeps its last value.
  - If saturation and rise happen in the same cycle, rise wins. It is treated as a normal edge and period = 2^CNT_WIDTH-1.
- TIMEOUT:
  - cnt is held. timeout stays at 1.
  - On rise: timeout <= 0, cnt <= 1, go to MEASURE. No period_valid on this edge.
- Minimum measurable period is 2 cycles. Shorter input pulses may be missed. This is acceptable and not flagged.
- period_valid is never high for two consecutive cycles.
- Reset asserted at any point forces all reset values on the next edge. Any in-flight count is discarded. The first rise after reset is treated as in IDLE.
- A constant-high or constant-low sig_in after lock produces TIMEOUT after 2^CNT_WIDTH-1 cycles.
- There are no combinational paths from inputs to outputs. All outputs are registered.

Optional Feature:
- Macro: DUTY_MEAS_EN.
- Defined:
  - Adds output high_time [CNT_WIDTH-1:0], reset value 0.
  - A second counter counts cycles with s_sync == 1 since the last rise. It saturates at 2^CNT_WIDTH-1.
  - On each rise that updates period, high_time <= the high-count and the high-count restarts.
  - high_time is updated in the same cycle as period, under the same period_valid strobe.
  - high_time is not updated in IDLE or TIMEOUT exits.
- Not defined: the high_time port and its counter do not exist. All other behaviour is identical.

Test Plan:
- Reset, then sig_in driven by a divider toggling every 10 clk_in cycles (period 20).
  - Required: first period_valid after the second detected rise, with period = 20.
  - Then period_valid every 20 cycles, with locked = 1 from the first pulse.
- Hand-driven rises 7, then 13, then 2 cycles apart.
  - Required: period = 7, then 13, then 2, each with a single-cycle period_valid.
- CNT_WIDTH = 4, sig_in held low after lock.
  - Required: timeout = 1 and locked = 0 exactly 15 cycles after the last rise. period is unchanged.
  - Next rise clears timeout with no strobe. The following rise 9 cycles later gives period = 9.
- reset asserted for 1 cycle mid-period while locked with period = 20.
  - Required: all outputs 0 on the next cycle.
  - The first post-reset rise gives no strobe. The second rise gives the correct period.
- With DUTY_MEAS_EN defined, input high 6 cycles and low 14 cycles.
  - Required: period = 20 and high_time = 6 on every strobe after the first.
- Rise coinciding with saturation (CNT_WIDTH = 4, rises 15 cycles apart).
  - Required: period = 15, period_valid = 1, timeout stays 0.

Source files
------------

// File: rtl/clk_period_meter.sv
// clk_period_meter: synchronises a slow square wave into clk_in and measures its rising-edge period.
// Optional macro DUTY_MEAS_EN adds the high_time output (high-phase length of each published period).
module clk_period_meter #(
    parameter int CNT_WIDTH   = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk_in,
    input  logic                 reset,
    input  logic                 sig_in,
`ifdef DUTY_MEAS_EN
    output logic [CNT_WIDTH-1:0] high_time,
`endif
    output logic [CNT_WIDTH-1:0] period,
    output logic                 period_valid,
    output logic                 timeout,
    output logic                 locked
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE,
        MEASURE,
        TIMEOUT
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_sync;
    logic                   s_prev;
    logic                   rise;
    logic [CNT_WIDTH-1:0]   cnt;

    assign s_sync = sync_q[SYNC_STAGES-1];
    assign rise   = s_sync & ~s_prev;

    // sig_in is asynchronous; sync_q[0] may go metastable, so only the last stage is used.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            sync_q <= '0;
            s_prev <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
            s_prev <= s_sync;
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            timeout      <= 1'b0;
            locked       <= 1'b0;
        end else begin
            period_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (rise) begin
                        cnt   <= CNT_ONE;
                        state <= MEASURE;
                    end else begin
                        cnt <= '0;
                    end
                end
                MEASURE: begin
                    // A rise on the saturation cycle still counts as a normal edge.
                    if (rise) begin
                        period       <= cnt;
                        period_valid <= 1'b1;
                        locked       <= 1'b1;
                        cnt          <= CNT_ONE;
                    end else if (cnt == CNT_MAX) begin
                        state   <= TIMEOUT;
                        timeout <= 1'b1;
                        locked  <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                TIMEOUT: begin
                    if (rise) begin
                        timeout <= 1'b0;
                        cnt     <= CNT_ONE;
                        state   <= MEASURE;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

`ifdef DUTY_MEAS_EN
    logic [CNT_WIDTH-1:0] high_cnt;

    // The rise cycle itself is the first high cycle, hence the restart at one.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            high_cnt  <= '0;
            high_time <= '0;
        end else begin
            if (rise) begin
                high_cnt <= CNT_ONE;
            end else if (s_sync && (high_cnt != CNT_MAX)) begin
                high_cnt <= high_cnt + CNT_ONE;
            end
            if (rise && (state == MEASURE)) begin
                high_time <= high_cnt;
            end
        end
    end
`endif

endmodule

// File: tb/tb_clk_period_meter.sv
// tb_clk_period_meter: directed checks of clk_period_meter with a 16-bit and a 4-bit counter instance.
// Inputs change and outputs are sampled on the falling edge; a rise driven at step k shows at step k+3.
module tb_clk_period_meter;

    logic        clk = 1'b0;
    logic        reset;
    logic        sig_a;
    logic        sig_b;
    logic [15:0] a_period;
    logic        a_valid;
    logic        a_timeout;
    logic        a_locked;
    logic [3:0]  b_period;
    logic        b_valid;
    logic        b_timeout;
    logic        b_locked;
`ifdef DUTY_MEAS_EN
    logic [15:0] a_high;
    logic [3:0]  b_high;
`endif

    int   passed = 0;
    int   failed = 0;
    int   total  = 0;
    int   step   = 0;
    logic pv;

    always #5 clk = ~clk;

    clk_period_meter #(.CNT_WIDTH(16), .SYNC_STAGES(2)) dut_a (
        .clk_in       (clk),
        .reset        (reset),
        .sig_in       (sig_a),
`ifdef DUTY_MEAS_EN
        .high_time    (a_high),
`endif
        .period       (a_period),
        .period_valid (a_valid),
        .timeout      (a_timeout),
        .locked       (a_locked)
    );

    clk_period_meter #(.CNT_WIDTH(4), .SYNC_STAGES(2)) dut_b (
        .clk_in       (clk),
        .reset        (reset),
        .sig_in       (sig_b),
`ifdef DUTY_MEAS_EN
        .high_time    (b_high),
`endif
        .period       (b_period),
        .period_valid (b_valid),
        .timeout      (b_timeout),
        .locked       (b_locked)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) begin
            passed++;
        end else begin
            failed++;
            $error("[TB] FAIL %s at step %0d: observed %0d, expected %0d", tag, step, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic a, input logic b, input logic r);
        sig_a = a;
        sig_b = b;
        reset = r;
    endtask

    initial begin
        applyStimulus(1'b0, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        checkOutput("rst_a_period", a_period, 0);
        checkOutput("rst_a_valid", a_valid, 0);
        checkOutput("rst_a_timeout", a_timeout, 0);
        checkOutput("rst_a_locked", a_locked, 0);
        checkOutput("rst_b_period", b_period, 0);
        checkOutput("rst_b_locked", b_locked, 0);
`ifdef DUTY_MEAS_EN
        checkOutput("rst_a_high", a_high, 0);
`endif
        applyStimulus(1'b0, 1'b0, 1'b0);

        $display("[TB] divider input, period 20");
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            step = k;
            pv = k inside {33, 53, 73};
            checkOutput("t1_valid", a_valid, pv);
            checkOutput("t1_locked", a_locked, k >= 33);
            if (pv) begin
                checkOutput("t1_period", a_period, 20);
`ifdef DUTY_MEAS_EN
                checkOutput("t1_high", a_high, 10);
`endif
            end
            applyStimulus(((k / 10) % 2) == 1, 1'b0, 1'b0);
        end

        $display("[TB] hand-driven rises 7, 13, 2 apart");
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            step = k;
            pv = k inside {5, 12, 25, 27};
            checkOutput("t2_valid", a_valid, pv);
            if (pv) begin
                checkOutput("t2_period", a_period, (k == 5) ? 12 : (k == 12) ? 7 : (k == 25) ? 13 : 2);
`ifdef DUTY_MEAS_EN
                checkOutput("t2_high", a_high, (k == 5) ? 10 : 1);
`endif
            end
            applyStimulus(k inside {2, 9, 22, 24}, 1'b0, 1'b0);
        end

        $display("[TB] reset mid-period while locked");
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            step = k;
            pv = k inside {7, 27, 54};
            checkOutput("t4_valid", a_valid, pv);
            checkOutput("t4_locked", a_locked, (k < 35) || (k >= 54));
            if (pv) begin
                checkOutput("t4_period", a_period, (k == 7) ? 10 : (k == 27) ? 20 : 11);
`ifdef DUTY_MEAS_EN
                checkOutput("t4_high", a_high, 1);
`endif
            end
            if (k == 35 || k == 43) begin
                checkOutput("t4_rst_period", a_period, 0);
                checkOutput("t4_rst_timeout", a_timeout, 0);
`ifdef DUTY_MEAS_EN
                checkOutput("t4_rst_high", a_high, 0);
`endif
            end
            applyStimulus(k inside {4, 24, 40, 51}, 1'b0, k == 34);
        end

        $display("[TB] duty input, high 6 low 14");
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            step = k;
            pv = k inside {3, 23, 43, 63};
            checkOutput("t5_valid", a_valid, pv);
            checkOutput("t5_locked", a_locked, 1);
            if (pv) begin
                checkOutput("t5_period", a_period, (k == 3) ? 9 : 20);
`ifdef DUTY_MEAS_EN
                checkOutput("t5_high", a_high, (k == 3) ? 1 : 6);
`endif
            end
            applyStimulus((k % 20) < 6, 1'b0, 1'b0);
        end

        $display("[TB] 4-bit counter: timeout, recovery, saturation edge");
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            step = k;
            pv = k inside {8, 42, 57};
            checkOutput("t3_valid", b_valid, pv);
            checkOutput("t3_timeout", b_timeout, (k >= 23) && (k < 33));
            checkOutput("t3_locked", b_locked, ((k >= 8) && (k < 23)) || (k >= 42));
            if (pv) begin
                checkOutput("t3_period", b_period, (k == 8) ? 5 : (k == 42) ? 9 : 15);
`ifdef DUTY_MEAS_EN
                checkOutput("t3_high", b_high, 1);
`endif
            end
            if (k == 23 || k == 33) begin
                checkOutput("t3_hold_period", b_period, 5);
            end
            applyStimulus(1'b0, k inside {0, 5, 30, 39, 54}, 1'b0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
